// File: rtl/alu_exec.sv
`timescale 1ns/1ps
// Execution stage: single-cycle ALU ops plus an iterative shift-add multiplier,
// with a registered result, write-enable pulse and {V,N,C,Z} flags register.
//
// state   | meaning
// ST_IDLE | accepting ops; single-cycle ops complete on the accept edge
// ST_MUL  | shift-add iterations in progress; start is ignored
module alu_exec #(
    parameter int DATA_BUS_WIDTH = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      start,
    input  logic [3:0]                op_sel,
    input  logic [DATA_BUS_WIDTH-1:0] operand_a,
    input  logic [DATA_BUS_WIDTH-1:0] operand_b,
    output logic [DATA_BUS_WIDTH-1:0] result,
    output logic                      result_valid,
    output logic                      result_we,
    output logic                      busy,
    output logic [3:0]                flags
);

    localparam int W  = DATA_BUS_WIDTH;
    localparam int CW = $clog2(W) + 1;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_MUL = 4'd7;
    localparam logic [3:0] OP_ADC = 4'd8;
    localparam logic [3:0] OP_CMP = 4'd9;

    localparam int FLAG_C = 1;

    localparam logic [CW-1:0] CNT_LOAD = CW'(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);
    localparam logic [CW-1:0] CNT_STEP = CW'(1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [2*W-1:0] r_acc;
    logic [2*W-1:0] r_mcand;
    logic [W-1:0]   r_mplier;
    logic [CW-1:0]  r_count;
    logic [W-1:0]   r_result;
    logic [3:0]     r_flags;
    logic           r_valid;
    logic           r_we;

    logic [2*W-1:0] w_acc_next;
    logic [2*W-1:0] w_mcand_next;
    logic [W-1:0]   w_mplier_next;
    logic [CW-1:0]  w_count_next;
    logic [W-1:0]   w_result_next;
    logic [3:0]     w_flags_next;
    logic           w_valid_next;
    logic           w_we_next;

    logic [W:0]     w_wide;
    logic [W-1:0]   w_alu_res;
    logic           w_alu_c;
    logic           w_alu_v;
    logic           w_alu_we;
    logic           w_alu_upd;

    logic [2*W-1:0] w_acc_step;
    logic [W-1:0]   w_mul_lo;
    logic           w_mul_hi_nz;

    // Single-cycle ALU; ADC takes its carry-in from the registered C flag.
    always_comb begin
        w_wide    = '0;
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        w_alu_v   = 1'b0;
        w_alu_we  = 1'b1;
        w_alu_upd = 1'b1;
        case (op_sel)
            OP_ADD, OP_ADC: begin
                w_wide = {1'b0, operand_a} + {1'b0, operand_b}
                       + {{W{1'b0}}, (op_sel == OP_ADC) & r_flags[FLAG_C]};
                w_alu_res = w_wide[W-1:0];
                w_alu_c   = w_wide[W];
                w_alu_v   = (operand_a[W-1] == operand_b[W-1])
                          && (w_alu_res[W-1] != operand_a[W-1]);
            end
            OP_SUB, OP_CMP: begin
                w_wide    = {1'b0, operand_a} - {1'b0, operand_b};
                w_alu_res = w_wide[W-1:0];
                w_alu_c   = w_wide[W];
                w_alu_v   = (operand_a[W-1] != operand_b[W-1])
                          && (w_alu_res[W-1] != operand_a[W-1]);
                w_alu_we  = (op_sel != OP_CMP);
            end
            OP_AND: w_alu_res = operand_a & operand_b;
            OP_OR:  w_alu_res = operand_a | operand_b;
            OP_XOR: w_alu_res = operand_a ^ operand_b;
            OP_SHL: begin
                w_alu_res = {operand_a[W-2:0], 1'b0};
                w_alu_c   = operand_a[W-1];
            end
            OP_SHR: begin
                w_alu_res = {1'b0, operand_a[W-1:1]};
                w_alu_c   = operand_a[0];
            end
            default: begin
                w_alu_we  = 1'b0;
                w_alu_upd = 1'b0;
            end
        endcase
    end

    assign w_acc_step  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign w_mul_lo    = w_acc_step[W-1:0];
    assign w_mul_hi_nz = |w_acc_step[2*W-1:W];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_acc_next    = r_acc;
        w_mcand_next  = r_mcand;
        w_mplier_next = r_mplier;
        w_count_next  = r_count;
        w_result_next = r_result;
        w_flags_next  = r_flags;
        w_valid_next  = 1'b0;
        w_we_next     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (op_sel == OP_MUL) begin
                        w_state_next  = ST_MUL;
                        w_acc_next    = '0;
                        w_mcand_next  = {{W{1'b0}}, operand_a};
                        w_mplier_next = operand_b;
                        w_count_next  = CNT_LOAD;
                    end else begin
                        w_valid_next = 1'b1;
                        w_we_next    = w_alu_we;
                        if (w_alu_upd) begin
                            w_result_next = w_alu_res;
                            w_flags_next  = {w_alu_v, w_alu_res[W-1], w_alu_c,
                                             (w_alu_res == '0)};
                        end
                    end
                end
            end
            ST_MUL: begin
                w_acc_next    = w_acc_step;
                w_mcand_next  = r_mcand << 1;
                w_mplier_next = r_mplier >> 1;
                w_count_next  = r_count - CNT_STEP;
                // Last iteration: publish the product in the same edge.
                if (r_count == CNT_LAST) begin
                    w_state_next  = ST_IDLE;
                    w_valid_next  = 1'b1;
                    w_we_next     = 1'b1;
                    w_result_next = w_mul_lo;
                    w_flags_next  = {1'b0, w_mul_lo[W-1], w_mul_hi_nz,
                                     (w_mul_lo == '0)};
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_count  <= '0;
            r_result <= '0;
            r_flags  <= '0;
            r_valid  <= 1'b0;
            r_we     <= 1'b0;
        end else begin
            r_acc    <= w_acc_next;
            r_mcand  <= w_mcand_next;
            r_mplier <= w_mplier_next;
            r_count  <= w_count_next;
            r_result <= w_result_next;
            r_flags  <= w_flags_next;
            r_valid  <= w_valid_next;
            r_we     <= w_we_next;
        end
    end

    assign result       = r_result;
    assign flags        = r_flags;
    assign result_valid = r_valid;
    assign result_we    = r_we;
    assign busy         = (r_state == ST_MUL);

endmodule

// File: doc/alu_exec.md
# alu_exec

Execution stage of the 8-bit datapath. It sits directly downstream of the register file. It takes the two register read ports as operands and a decoded operation from control, then returns a registered result with a write-enable that feeds back into the register file write port. It also keeps the processor flags register. Single-cycle ops complete in one clock; MUL is an iterative shift-add that runs over DATA_BUS_WIDTH clocks and reports busy while it runs.

## Interface
- DATA_BUS_WIDTH, default 8: operand, result and multiplier-iteration width.
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request to execute op_sel on operand_a and operand_b. Sampled only while busy=0.
- op_sel  input  4  operation code: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL, 8 ADC, 9 CMP, 10–15 NOP.
- operand_a  input  DATA_BUS_WIDTH  first operand (register file read port 1).
- operand_b  input  DATA_BUS_WIDTH  second operand (register file read port 2).
- result  output  DATA_BUS_WIDTH  registered result.
- result_valid  output  1  one-cycle pulse when an accepted op completes.
- result_we  output  1  pulses with result_valid when result must be written back. It is 0 for CMP and NOP.
- busy  output  1  high while a MUL is in progress.
- flags  output  4  {V, N, C, Z}, registered.

## Operation
- State machine: IDLE, MUL.
  - IDLE + start + op 7 → MUL.
  - MUL → IDLE after DATA_BUS_WIDTH iterations.
  - All other accepted ops stay in IDLE.
- Operands are captured at the accept edge. Later changes on operand_a/operand_b have no effect on an op in flight.
- Arithmetic is W = DATA_BUS_WIDTH bits. The result is truncated to W bits. Each op sets flags as follows:
  - ADD: a+b. C = carry-out of bit W−1. V = signed overflow.
  - SUB: a−b. C = borrow (a<b unsigned). V = signed overflow.
  - ADC: a+b+C_flag. C and V as for ADD.
  - AND, OR, XOR: bitwise. C = 0, V = 0.
  - SHL: a<<1. C = a[W−1], V = 0.
  - SHR: a>>1 (logical). C = a[0], V = 0. operand_b is ignored.
  - MUL: unsigned a×b. result = low W bits. C = 1 if the high W bits are nonzero. V = 0.
  - CMP: computed as SUB. Flags and result are updated, result_we = 0.
  - NOP: result_valid pulses, result_we = 0. result and flags are unchanged.
- Z = (result == 0) and N = result[W−1]. Both are derived from the new result for every non-NOP op.
- MUL datapath:
  - 2W-bit accumulator, W-bit shifted multiplier, iteration counter of clog2(W)+1 bits.
  - Each iteration: if multiplier LSB = 1, add the shifted multiplicand into the accumulator; then shift.
- Flags update only when the op completes, never during MUL iterations.

## Timing
- Reset (asynchronous, any cycle) forces:
  - result = 0, result_valid = 0, result_we = 0, busy = 0, flags = 0, state = IDLE.
  - Accumulator and counter cleared.
- Reset during MUL aborts the op. No result_valid is produced for it.
- Single-cycle ops: with start accepted at edge k, result, flags, result_valid and result_we are valid after edge k. Latency is 1.
- MUL accepted at edge k:
  - busy = 1 after edge k.
  - Iterations run at edges k+1 … k+W.
  - At edge k+W: result, flags, result_valid = 1, result_we = 1, and busy returns to 0.
  - Latency is W+? For W=8, valid follows 8 edges after accept.
- start while busy = 1 is ignored. No queuing, no error signal.
- A new start may be accepted on the same edge that completes a MUL only if busy is already 0 at that edge. In practice the first new accept is at edge k+W+1.
- Back-to-back single-cycle ops are allowed every clock. result_valid stays high across consecutive accepts.
- ADC uses the C flag as registered before its accept edge. A preceding op's carry is therefore visible to an ADC issued the very next cycle.

## Test plan
- Reset: assert reset mid-cycle with random inputs → result = 0x00, flags = 0, busy = 0, result_valid = 0 immediately (asynchronous). Hold after release until the first start.
- ADD 0xFF+0x01 → result 0x00, Z=1, C=1, V=0, N=0, result_valid = result_we = 1 one edge later. Follow the next cycle with ADC 0x10+0x20 → 0x31, C=0.
- SUB 0x80−0x01 → 0x7F, V=1, C=0, N=0. Then CMP 0x05,0x05 → Z=1, C=0, result_we=0, result_valid=1.
- Shifts: SHL 0x81 → 0x02, C=1. SHR 0x81 → 0x40, C=1.
- MUL (W=8):
  - 0x0F×0x11 → 0xFF, C=0, N=1. busy high 8 cycles, result_valid 8 edges after accept.
  - A start(ADD) issued mid-MUL is ignored (no extra result_valid).
  - Then 0x10×0x10 → 0x00, Z=1, C=1.
- Reset mid-MUL after 4 iterations → busy = 0, no result_valid, flags = 0. A following ADD 0x02+0x03 → 0x05 with 1-cycle latency.
